regfile_uart_ctrl: RTL
======================

Name: regfile_uart_ctrl

Overview:
- Sequences configuration-register access over the chip UART. Sits in the digital core between uart_rx, uart_tx and the config regfile.
- Pops each received 18-bit packet, checks parity, and decodes it as a write or a read. Writes go to the regfile; reads fetch the regfile word and return a response packet through uart_tx.
- Is the single owner of the regfile port and of the uart_tx load handshake.

Parameters:
- NUMREGS, 9: number of implemented registers; valid addresses are 0..NUMREGS-1.
- WIDTH, 18: UART packet width. Layout: bit 17 parity, bits 16:9 addr, bits 8:1 data, bit 0 wrb.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  18  packet from uart_rx; valid the cycle after uld_rx_data.
- rx_empty  in  1  low when uart_rx holds an unread packet.
- uld_rx_data  out  1  one-cycle unload strobe to uart_rx.
- tx_data  out  18  response packet to uart_tx.
- ld_tx_data  out  1  load request to uart_tx; held until tx_busy is seen high.
- tx_busy  in  1  uart_tx is transmitting.
- regfile_addr  out  8  regfile address.
- regfile_wdata  out  8  regfile write data.
- regfile_we  out  1  one-cycle write strobe.
- regfile_re  out  1  one-cycle read strobe; regfile_rdata is valid on the next cycle.
- regfile_rdata  in  8  regfile read data.
- parity_err_cnt  out  8  saturating count of rejected packets.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, tx_data 0, state IDLE. Reset is asynchronous in every state; a packet in flight is dropped and no partial write or load occurs.
- Parity: a packet is good when bits 17:0 contain an odd number of ones. Response packets set bit 17 so that they also have odd parity.
- Write/read encoding: wrb=0 is a write, wrb=1 is a read.
- FSM states: IDLE, UNLOAD, CAPTURE, DECODE, WRITE, READ, READ_WAIT, RESP_LOAD, RESP_ACK.
- IDLE: when rx_empty=0, go to UNLOAD.
- UNLOAD: drive uld_rx_data=1 for exactly one cycle, then go to CAPTURE.
- CAPTURE: register rx_data into pkt, then go to DECODE.
- DECODE, bad parity: increment parity_err_cnt (saturating at 0xFF), go to IDLE. No regfile access, no response.
- DECODE, good parity with wrb=0: go to WRITE.
- DECODE, good parity with wrb=1: go to READ.
- WRITE, addr < NUMREGS: regfile_we=1 for one cycle, with addr and data driven from pkt.
- WRITE, addr >= NUMREGS: the write is silently discarded (we stays 0).
- WRITE exit: go to IDLE, or to RESP_LOAD when WRITE_ECHO_EN is defined.
- READ, addr < NUMREGS: regfile_re=1 for one cycle, go to READ_WAIT.
- READ_WAIT: latch regfile_rdata as the response data.
- READ, addr >= NUMREGS: skip the regfile access; response data is 0x00.
- Response packet: {parity, addr, data, 1'b1}. Loaded into tx_data on entry to RESP_LOAD and held stable until RESP_ACK exits.
- RESP_LOAD: wait until tx_busy=0, then assert ld_tx_data. Hold it high until tx_busy=1 is sampled, drop it, and go to RESP_ACK.
- RESP_ACK: wait for tx_busy=0, then go to IDLE.
- Packet ordering:
  - Only one packet is in service at a time.
  - A packet arriving mid-service waits in uart_rx; rx_empty stays low and it is popped on the next IDLE.
  - A response is never preempted.
- regfile_addr and regfile_wdata are held at their last values when idle. regfile_we and regfile_re are never high in the same cycle.
- Latency from rx_empty falling:
  - Write: regfile_we high at cycle 4 (IDLE=0, UNLOAD=1, CAPTURE=2, DECODE=3, WRITE=4).
  - Read with tx idle: ld_tx_data high at cycle 7.

Optional Feature:
- Macro: REGFILE_UART_CTRL_WRITE_ECHO_EN.
- Defined: every accepted write, in range or not, produces an echo response {parity, addr, data, wrb=1}. The echoed data is the value written, or 0x00 when the address is out of range.
- Undefined: writes produce no UART traffic; the RESP path is used by reads only.

Test Plan:
- Write: reset, then rx packet 0x2074A (addr 0x03, data 0xA5, wrb 0) -> one regfile_we pulse with addr 0x03, wdata 0xA5 at cycle 4. No ld_tx_data (echo off). parity_err_cnt stays 0.
- Read-back: after the write, rx packet 0x00601 (read addr 0x03) -> regfile_re pulse, then tx_data=0x0074B with ld_tx_data held until tx_busy rises. busy returns to 0 after tx_busy falls.
- Parity error: rx packet 0x0074A -> no we/re/ld_tx_data, parity_err_cnt=1. After 300 bad packets, parity_err_cnt=0xFF.
- Out of range: write addr 0x09 -> no regfile_we. Read packet 0x01201 -> no regfile_re, tx_data=0x01201 (data 0x00).
- Back-pressure: hold tx_busy=1 for 500 cycles during a read response -> ld_tx_data stays 0 until tx_busy falls, with tx_data stable. A second queued packet is not unloaded until IDLE.
- Reset mid-operation: assert reset_n=0 while in RESP_LOAD -> all outputs 0 immediately, parity_err_cnt=0. After release, the next packet is served normally.
- Echo build: with REGFILE_UART_CTRL_WRITE_ECHO_EN defined, rx packet 0x2074A -> regfile_we pulse, then tx_data=0x0074B.

Source files
------------

// File: rtl/regfile_uart_ctrl.sv
// rtl/regfile_uart_ctrl.sv - sequences config-regfile writes/reads carried in UART packets
// Optional write echo response: define REGFILE_UART_CTRL_WRITE_ECHO_EN.
module regfile_uart_ctrl #(
    parameter int NUMREGS = 9,
    parameter int WIDTH   = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_empty,
    output logic             uld_rx_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    output logic [7:0]       regfile_addr,
    output logic [7:0]       regfile_wdata,
    output logic             regfile_we,
    output logic             regfile_re,
    input  logic [7:0]       regfile_rdata,
    output logic [7:0]       parity_err_cnt,
    output logic             busy
);
    typedef enum logic [3:0] {
        IDLE, UNLOAD, CAPTURE, DECODE, WRITE, READ, READ_WAIT, RESP_LOAD, RESP_ACK
    } state_t;

    localparam logic [8:0] ADDR_LIMIT = 9'(NUMREGS);

    state_t           state;
    logic [WIDTH-1:0] pkt;
    logic [7:0]       pkt_addr;
    logic [7:0]       pkt_data;
    logic             pkt_wrb;
    logic             pkt_parity_ok;
    logic             pkt_in_range;

    assign pkt_addr      = pkt[16:9];
    assign pkt_data      = pkt[8:1];
    assign pkt_wrb       = pkt[0];
    assign pkt_parity_ok = ^pkt;
    assign pkt_in_range  = ({1'b0, pkt_addr} < ADDR_LIMIT);
    assign busy          = (state != IDLE);

    // Response always carries wrb=1; top bit makes the whole packet odd parity.
    function automatic logic [WIDTH-1:0] make_resp(input logic [7:0] addr, input logic [7:0] data);
        logic [WIDTH-2:0] body;
        body = {addr, data, 1'b1};
        return {~^body, body};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pkt            <= '0;
            uld_rx_data    <= 1'b0;
            tx_data        <= '0;
            ld_tx_data     <= 1'b0;
            regfile_addr   <= 8'h00;
            regfile_wdata  <= 8'h00;
            regfile_we     <= 1'b0;
            regfile_re     <= 1'b0;
            parity_err_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        uld_rx_data <= 1'b1;
                        state       <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    uld_rx_data <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    pkt   <= rx_data;
                    state <= DECODE;
                end
                DECODE: begin
                    if (!pkt_parity_ok) begin
                        if (parity_err_cnt != 8'hFF) parity_err_cnt <= parity_err_cnt + 8'h01;
                        state <= IDLE;
                    end else if (pkt_wrb) begin
                        regfile_addr <= pkt_addr;
                        regfile_re   <= pkt_in_range;
                        state        <= READ;
                    end else begin
                        regfile_addr  <= pkt_addr;
                        regfile_wdata <= pkt_data;
                        regfile_we    <= pkt_in_range;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    regfile_we <= 1'b0;
`ifdef REGFILE_UART_CTRL_WRITE_ECHO_EN
                    tx_data <= make_resp(pkt_addr, pkt_in_range ? pkt_data : 8'h00);
                    state   <= RESP_LOAD;
`else
                    state   <= IDLE;
`endif
                end
                READ: begin
                    regfile_re <= 1'b0;
                    if (pkt_in_range) begin
                        state <= READ_WAIT;
                    end else begin
                        tx_data <= make_resp(pkt_addr, 8'h00);
                        state   <= RESP_LOAD;
                    end
                end
                READ_WAIT: begin
                    tx_data <= make_resp(pkt_addr, regfile_rdata);
                    state   <= RESP_LOAD;
                end
                RESP_LOAD: begin
                    // Raise the load only into an idle transmitter, drop it once it is taken.
                    if (!ld_tx_data) begin
                        if (!tx_busy) ld_tx_data <= 1'b1;
                    end else if (tx_busy) begin
                        ld_tx_data <= 1'b0;
                        state      <= RESP_ACK;
                    end
                end
                RESP_ACK: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
